// File: rtl/elixirchip_es1_spu_delay_pipe.sv
// rtl/elixirchip_es1_spu_delay_pipe.sv - fixed-latency data/valid delay line with clear-to-zero and hold-on-idle capture
module elixirchip_es1_spu_delay_pipe #(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_clear,
    input  logic                 s_valid,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid
);

    generate
        if (LATENCY == 0) begin : g_bypass
            // Zero depth: the pipe collapses to the input mux; clock, reset and cke are unused.
            always_comb begin
                m_data  = s_clear ? '0 : s_data;
                m_valid = s_valid;
            end
        end else begin : g_pipe
            logic [DATA_BITS-1:0] data_q [LATENCY];
            logic [LATENCY-1:0]   valid_q;
            logic [DATA_BITS-1:0] data_d;

            // First data stage: clear wins, otherwise capture only valid input, else keep the last captured word.
            always_comb begin
                data_d = data_q[0];
                if (s_clear) begin
                    data_d = '0;
                end else if (s_valid) begin
                    data_d = s_data;
                end
            end

            // Shift both chains on enabled cycles; reset empties the pipe regardless of cke.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        data_q[i]  <= '0;
                        valid_q[i] <= 1'b0;
                    end
                end else if (cke) begin
                    data_q[0]  <= data_d;
                    valid_q[0] <= s_valid;
                    for (int i = 1; i < LATENCY; i++) begin
                        data_q[i]  <= data_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign m_data  = data_q[LATENCY-1];
            assign m_valid = valid_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_delay_pipe.sv
// tb/tb_elixirchip_es1_spu_delay_pipe.sv - scoreboard bench driving depth 0/2/3/4 pipes from one shared stimulus stream
module tb_elixirchip_es1_spu_delay_pipe;

    logic       clk;
    logic       reset;
    logic       cke;
    logic [7:0] s_data;
    logic       s_clear;
    logic       s_valid;
    logic [7:0] m_data0, m_data2, m_data3, m_data4;
    logic       m_valid0, m_valid2, m_valid3, m_valid4;

    int checks   = 0;
    int failures = 0;

    // Scoreboard state: last captured word, and per-depth queues of expected {valid,data}; entry 0 is the output stage.
    logic [7:0] cap_m;
    logic [8:0] q2[$];
    logic [8:0] q3[$];
    logic [8:0] q4[$];

    elixirchip_es1_spu_delay_pipe #(.LATENCY(0), .DATA_BITS(8)) u_l0 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(m_data0), .m_valid(m_valid0));
    elixirchip_es1_spu_delay_pipe #(.LATENCY(2), .DATA_BITS(8)) u_l2 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(m_data2), .m_valid(m_valid2));
    elixirchip_es1_spu_delay_pipe #(.LATENCY(3), .DATA_BITS(8)) u_l3 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(m_data3), .m_valid(m_valid3));
    elixirchip_es1_spu_delay_pipe #(.LATENCY(4), .DATA_BITS(8)) u_l4 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(m_data4), .m_valid(m_valid4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check the combinational pipe, advance the model, check the registered pipes.
    task automatic step(input logic rst, input logic ce, input logic clr, input logic vld, input logic [7:0] dat);
        logic [8:0] item;
        @(negedge clk);
        reset   = rst;
        cke     = ce;
        s_clear = clr;
        s_valid = vld;
        s_data  = dat;
        #1;
        chk("l0_out", {m_valid0, m_data0}, {vld, (clr ? 8'h00 : dat)});
        if (rst) begin
            cap_m = 8'h00;
            q2.delete();
            q3.delete();
            q4.delete();
            for (int i = 0; i < 2; i++) q2.push_back(9'h000);
            for (int i = 0; i < 3; i++) q3.push_back(9'h000);
            for (int i = 0; i < 4; i++) q4.push_back(9'h000);
        end else if (ce) begin
            if (clr)      cap_m = 8'h00;
            else if (vld) cap_m = dat;
            item = {vld, cap_m};
            q2.push_back(item); void'(q2.pop_front());
            q3.push_back(item); void'(q3.pop_front());
            q4.push_back(item); void'(q4.pop_front());
        end
        @(posedge clk);
        #1;
        chk("l2_out", {m_valid2, m_data2}, q2[0]);
        chk("l3_out", {m_valid3, m_data3}, q3[0]);
        chk("l4_out", {m_valid4, m_data4}, q4[0]);
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; s_clear = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        cap_m = 8'h00;

        // Reset state
        step(1, 1, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        chk("rst_l4", {m_valid4, m_data4}, 9'h000);

        // Depth 3 stream 11..44
        step(0, 1, 0, 1, 8'h11);
        step(0, 1, 0, 1, 8'h22);
        chk("l3_not_early", {m_valid3, m_data3}, 9'h000);
        step(0, 1, 0, 1, 8'h33);
        chk("l3_first", {m_valid3, m_data3}, 9'h111);
        step(0, 1, 0, 1, 8'h44);
        chk("l3_second", {m_valid3, m_data3}, 9'h122);
        step(0, 1, 0, 0, 8'h00);
        chk("l3_third", {m_valid3, m_data3}, 9'h133);
        step(0, 1, 0, 0, 8'h00);
        chk("l3_fourth", {m_valid3, m_data3}, 9'h144);
        step(0, 1, 0, 0, 8'h00);
        chk("l3_idle_hold", {m_valid3, m_data3}, 9'h044);

        // Depth 2 clear beats valid
        step(0, 1, 1, 1, 8'hA5);
        step(0, 1, 0, 0, 8'h00);
        chk("l2_clear", {m_valid2, m_data2}, 9'h100);

        // Depth 2 hold when valid low
        step(0, 1, 0, 1, 8'h33);
        step(0, 1, 0, 0, 8'h5A);
        chk("l2_capture", {m_valid2, m_data2}, 9'h133);
        step(0, 1, 0, 0, 8'h5A);
        chk("l2_hold_a", {m_valid2, m_data2}, 9'h033);
        step(0, 1, 0, 0, 8'h5A);
        chk("l2_hold_b", {m_valid2, m_data2}, 9'h033);

        // Depth 3 with a two-cycle cke stall
        step(0, 1, 0, 1, 8'h01);
        step(0, 1, 0, 1, 8'h02);
        step(0, 1, 0, 1, 8'h03);
        chk("stall_pre", {m_valid3, m_data3}, 9'h101);
        step(0, 0, 0, 1, 8'hFF);
        chk("stall_frz_a", {m_valid3, m_data3}, 9'h101);
        step(0, 0, 1, 1, 8'hFF);
        chk("stall_frz_b", {m_valid3, m_data3}, 9'h101);
        step(0, 1, 0, 1, 8'h04);
        chk("stall_resume", {m_valid3, m_data3}, 9'h102);
        step(0, 1, 0, 1, 8'h05);
        step(0, 1, 0, 1, 8'h06);
        chk("stall_item4", {m_valid3, m_data3}, 9'h104);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        chk("stall_item6", {m_valid3, m_data3}, 9'h106);

        // Depth 4 mid-stream reset, with cke low and clear/valid asserted to show reset priority
        step(0, 1, 0, 1, 8'h81);
        step(0, 1, 0, 1, 8'h82);
        step(0, 1, 0, 1, 8'h83);
        step(1, 0, 0, 1, 8'h99);
        chk("mid_rst_l4", {m_valid4, m_data4}, 9'h000);
        chk("mid_rst_l2", {m_valid2, m_data2}, 9'h000);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 8'h55);
            chk("post_rst_l4", {m_valid4, m_data4}, 9'h000);
        end

        // Depth 0 pass-through
        step(0, 1, 0, 1, 8'h7E);
        step(0, 1, 0, 0, 8'h7E);
        step(0, 0, 0, 1, 8'h7E);
        step(0, 1, 1, 1, 8'h7E);
        step(1, 1, 0, 1, 8'h7E);

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
